// File: rtl/volume_key_ctrl_pkg.sv
// Shared types for the volume key command generator.
package vol_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2
  } cmd_t;

  localparam int NUM_KEYS = 2;
  localparam int KEY_UP_IDX = 0;
  localparam int KEY_DOWN_IDX = 1;

  // Exactly one key down is a command; both or neither is not.
  function automatic cmd_t decode_cmd(input logic up, input logic down);
    if (up && !down)      return CMD_UP;
    else if (down && !up) return CMD_DOWN;
    else                  return CMD_NONE;
  endfunction

endpackage

// File: rtl/volume_key_ctrl_if.sv
// Raw key inputs and command strobe outputs of volume_key_ctrl.
interface volume_key_ctrl_if;
  logic KEY_UP;
  logic KEY_DOWN;
  logic VOLUP;
  logic VOLDOWN;
  logic VOLVALID;

  // master drives the buttons and consumes commands; slave is the controller
  modport master (output KEY_UP, KEY_DOWN, input VOLUP, VOLDOWN, VOLVALID);
  modport slave  (input KEY_UP, KEY_DOWN, output VOLUP, VOLDOWN, VOLVALID);
endinterface

// File: rtl/volume_key_ctrl_debounce.sv
// Per-key 2-flop synchroniser followed by a consecutive-mismatch debouncer.
module key_debounce #(
  parameter int DEBOUNCE_TICKS = 50_000,
  parameter int TIMER_W        = 32
) (
  input  logic CLK,
  input  logic RESET,
  input  logic KEY_RAW,
  output logic KEY_DB
);

  localparam logic [TIMER_W-1:0] DB_LAST = TIMER_W'(DEBOUNCE_TICKS - 1);

  logic               sync_1, sync_2;
  logic [TIMER_W-1:0] cnt;

  // Bring the asynchronous button level into the CLK domain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= KEY_RAW;
      sync_2 <= sync_1;
    end
  end

  // Flip the clean level only after DEBOUNCE_TICKS consecutive disagreeing cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt    <= '0;
      KEY_DB <= 1'b0;
    end else if (sync_2 != KEY_DB) begin
      if (cnt == DB_LAST) begin
        KEY_DB <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + TIMER_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/volume_key_ctrl.sv
// Volume key command generator: debounced up/down buttons drive a
// press / hold-delay / auto-repeat FSM issuing one-cycle command pulses.
module volume_key_ctrl
  import vol_key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 50_000,
  parameter int HOLD_TICKS     = 25_000_000,
  parameter int REPEAT_TICKS   = 5_000_000,
  parameter int TIMER_W        = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  volume_key_ctrl_if.slave bus
);

  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_TICKS - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_TICKS - 1);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_db;
  cmd_t                cmd;
  state_t              state;
  cmd_t                dir;
  logic [TIMER_W-1:0]  timer;
  logic                vld_q, up_q, dn_q;

  assign key_raw[KEY_UP_IDX]   = bus.KEY_UP;
  assign key_raw[KEY_DOWN_IDX] = bus.KEY_DOWN;

  key_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .TIMER_W        (TIMER_W)
  ) u_db [NUM_KEYS-1:0] (
    .CLK     (CLK),
    .RESET   (RESET),
    .KEY_RAW (key_raw),
    .KEY_DB  (key_db)
  );

  // Decode the debounced pair into a single command.
  always_comb begin
    cmd = decode_cmd(key_db[KEY_UP_IDX], key_db[KEY_DOWN_IDX]);
  end

  // Press / hold / repeat sequencing with registered command outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      dir   <= CMD_NONE;
      timer <= '0;
      vld_q <= 1'b0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (cmd != CMD_NONE) begin
            vld_q <= 1'b1;
            up_q  <= (cmd == CMD_UP);
            dn_q  <= (cmd == CMD_DOWN);
            dir   <= cmd;
            state <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          // release, second key or direction change all abort silently
          if (cmd != dir) begin
            timer <= '0;
            state <= ST_IDLE;
          end else if (timer == HOLD_LAST) begin
            vld_q <= 1'b1;
            up_q  <= (dir == CMD_UP);
            dn_q  <= (dir == CMD_DOWN);
            timer <= '0;
            state <= ST_REPEAT;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        ST_REPEAT: begin
          if (cmd != dir) begin
            timer <= '0;
            state <= ST_IDLE;
          end else if (timer == REPEAT_LAST) begin
            vld_q <= 1'b1;
            up_q  <= (dir == CMD_UP);
            dn_q  <= (dir == CMD_DOWN);
            timer <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
          timer <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.VOLVALID = vld_q;
  assign bus.VOLUP    = up_q;
  assign bus.VOLDOWN  = dn_q;

endmodule
